// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer slice.
// Widths, reset PC, FSM state enum and the prefetch queue entry.
package fetch_pkg;

  localparam int DATA_W = 72;
  localparam int ADDR_W = 72;
  localparam int DEF_DEPTH = 4;
  localparam logic [ADDR_W-1:0] DEF_RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t, DEPTH entries (power of 2).
// Ports: clk, reset, push/entry, pop, flush (beats push), count, head, empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch initiator: owns the PC, issues 1-cycle-latency fetches,
// queues returned words and hands them downstream via valid/ready.
// Ports: clk, reset, fetch_addr/fetch_instr, redirect_valid/pc, halt,
// out_valid/out_instr/out_pc/out_ready, busy.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic [DATA_W-1:0] fetch_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tag_pc;
  logic              inflight;
  fetch_entry_t      last;
  fetch_entry_t      head;
  fetch_entry_t      entry;
  logic [CW-1:0]     count;
  logic [CW-1:0]     used;
  logic              empty;
  logic              pop;
  logic              issue;

  assign pop = !empty && out_ready;

  // Credit: post-pop occupancy plus the word still in flight.
  assign used  = count - CW'(pop) + CW'(inflight);
  assign issue = (state == RUN) && !halt && !redirect_valid
              && (used < CW'(DEPTH));

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt) state_nxt = HALTED;
      HALTED:  if (!halt) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      tag_pc   <= RESET_PC;
      inflight <= 1'b0;
      last     <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) tag_pc <= pc;
      if (redirect_valid) pc <= redirect_pc;
      else if (issue) pc <= pc + 1'b1;
      if (pop) last <= head;
    end
  end

  assign entry = '{instr: fetch_instr, pc: tag_pc};

  // A redirect flushes the queue, which also drops the returning word.
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .entry (entry),
    .pop   (pop),
    .flush (redirect_valid),
    .count (count),
    .head  (head),
    .empty (empty)
  );

  // Outputs hold the last delivered entry while the queue is empty.
  assign fetch_addr = pc;
  assign out_valid  = !empty;
  assign out_instr  = empty ? last.instr : head.instr;
  assign out_pc     = empty ? last.pc : head.pc;
  assign busy       = (state == RUN) || inflight || !empty;

endmodule
